// File: rtl/riscv_mpsoc_pkg.sv
// riscv_mpsoc_pkg: shared AHB-Lite encodings, master-port FSM states and hold-register layout
// Ports: none (package). Imported by riscv_master_port and the bus-matrix helpers.
package riscv_mpsoc_pkg;
  localparam int AHB_PLEN = 64;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ERR1, ST_ERR2} port_state_t;
  typedef struct packed {
    logic [AHB_PLEN-1:0] addr;
    logic                write;
    logic [2:0]          size;
    logic [2:0]          burst;
    logic [3:0]          prot;
    logic [1:0]          trans;
    logic                lock;
  } hold_t;
endpackage

// File: rtl/riscv_master_port_if.sv
// riscv_master_port_if: bundle of one AHB master's bus plus the per-slave-port request/return lines
// Modports: slave  - the master port itself (takes mst* and slave-port returns, drives slv*/can_switch)
//           master - the surrounding master and slave ports (drive the other direction)
interface riscv_master_port_if #(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 8
);
  logic                         mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY;
  logic [PLEN-1:0]              mstHADDR;
  logic [XLEN-1:0]              mstHWDATA, mstHRDATA;
  logic [2:0]                   mstHSIZE, mstHBURST;
  logic [3:0]                   mstHPROT;
  logic [1:0]                   mstHTRANS;
  logic                         mstHREADYOUT, mstHRESP;
  logic [SLAVES-1:0][PLEN-1:0]  slvHADDR_BASE, slvHADDR_MASK;
  logic [SLAVES-1:0]            slvHSEL, slvHREADYOUT, slvHRESP, slvGRANT, can_switch;
  logic [PLEN-1:0]              slvHADDR;
  logic [XLEN-1:0]              slvHWDATA;
  logic                         slvHWRITE, slvHMASTLOCK, slvHREADY;
  logic [2:0]                   slvHSIZE, slvHBURST;
  logic [3:0]                   slvHPROT;
  logic [1:0]                   slvHTRANS;
  logic [SLAVES-1:0][XLEN-1:0]  slvHRDATA;
  modport slave (
    input  mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE, mstHBURST, mstHPROT, mstHTRANS,
           mstHMASTLOCK, mstHREADY, slvHADDR_BASE, slvHADDR_MASK, slvHRDATA, slvHREADYOUT,
           slvHRESP, slvGRANT,
    output mstHRDATA, mstHREADYOUT, mstHRESP, slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE,
           slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY, can_switch
  );
  modport master (
    output mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE, mstHBURST, mstHPROT, mstHTRANS,
           mstHMASTLOCK, mstHREADY, slvHADDR_BASE, slvHADDR_MASK, slvHRDATA, slvHREADYOUT,
           slvHRESP, slvGRANT,
    input  mstHRDATA, mstHREADYOUT, mstHRESP, slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE,
           slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY, can_switch
  );
endinterface

// File: rtl/riscv_ahb_addr_decoder.sv
// riscv_ahb_addr_decoder: combinational region decode, lowest matching region wins
// Ports: addr (in), base/mask per region (in), hit one-hot (out), unmapped when nothing matches (out)
module riscv_ahb_addr_decoder #(
  parameter int PLEN   = 64,
  parameter int SLAVES = 8
) (
  input  logic [PLEN-1:0]             addr,
  input  logic [SLAVES-1:0][PLEN-1:0] base,
  input  logic [SLAVES-1:0][PLEN-1:0] mask,
  output logic [SLAVES-1:0]           hit,
  output logic                        unmapped
);
  logic [SLAVES-1:0] raw;
  for (genvar i = 0; i < SLAVES; i++) begin : g_hit
    assign raw[i] = ~|((addr ^ base[i]) & mask[i]);
  end
  // isolate the lowest set bit so overlapping regions resolve to the lowest index
  assign hit      = raw & (~raw + SLAVES'(1));
  assign unmapped = ~|raw;
endmodule

// File: rtl/riscv_master_port.sv
// riscv_master_port: AHB-Lite master port of the MPSoC bus matrix
// Ports: HRESETn (async, active-low), HCLK, bus (riscv_master_port_if.slave: master-side transfer
//        stream in, per-slave-port requests/broadcast address phase out, selected slave's data
//        phase back to the master, can_switch per slave port)
// Build option: RISCV_MASTER_PORT_DEFAULT_SLAVE_EN adds a two-cycle ERROR response for unmapped
//        accesses; otherwise unmapped accesses complete as zero-wait OKAY with read data 0.
module riscv_master_port
  import riscv_mpsoc_pkg::*;
#(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 8
) (
  input logic                 HRESETn,
  input logic                 HCLK,
  riscv_master_port_if.slave  bus
);
  port_state_t       state;
  hold_t             hold;
  logic [SLAVES-1:0] hold_sel, dsel, dec_hit, asel;
  logic              dlock, dec_unmapped, pend, valid, sample, dp_ready, dp_resp, err1, err_any;
  logic              cur_lock, cur_seq_busy;
  logic [XLEN-1:0]   dp_rdata;

  riscv_ahb_addr_decoder #(.PLEN(PLEN), .SLAVES(SLAVES)) u_dec (
    .addr     (bus.mstHADDR),
    .base     (bus.slvHADDR_BASE),
    .mask     (bus.slvHADDR_MASK),
    .hit      (dec_hit),
    .unmapped (dec_unmapped)
  );

  assign pend  = state == ST_PEND;
  // NONSEQ and SEQ both have HTRANS[1] set
  assign valid = bus.mstHSEL & bus.mstHTRANS[1] & bus.mstHREADY;
  // a stalled data phase blocks sampling of the next address phase
  assign sample = bus.mstHREADY & dp_ready;

`ifdef RISCV_MASTER_PORT_DEFAULT_SLAVE_EN
  assign err1    = state == ST_ERR1;
  assign err_any = state == ST_ERR1 || state == ST_ERR2;
`else
  assign err1    = 1'b0;
  assign err_any = 1'b0;
`endif

  // dsel is one-hot; all-zero means no slave owns the current data phase
  always_comb begin
    dp_rdata = '0;
    dp_ready = 1'b1;
    dp_resp  = HRESP_OKAY;
    for (int s = 0; s < SLAVES; s++)
      if (dsel[s]) begin
        dp_rdata = bus.slvHRDATA[s];
        dp_ready = bus.slvHREADYOUT[s];
        dp_resp  = bus.slvHRESP[s];
      end
  end

  assign asel = (pend ? hold_sel : state == ST_IDLE ? dec_hit & {SLAVES{bus.mstHSEL}} : '0)
                & {SLAVES{HRESETn}};

  assign bus.slvHSEL      = asel;
  assign bus.slvHADDR     = pend ? PLEN'(hold.addr) : bus.mstHADDR;
  assign bus.slvHWRITE    = pend ? hold.write : bus.mstHWRITE;
  assign bus.slvHSIZE     = pend ? hold.size : bus.mstHSIZE;
  assign bus.slvHBURST    = pend ? hold.burst : bus.mstHBURST;
  assign bus.slvHPROT     = pend ? hold.prot : bus.mstHPROT;
  // only NONSEQ/SEQ are ever held, and a replayed beat must restart as NONSEQ
  assign bus.slvHTRANS    = pend ? HTRANS_NONSEQ : bus.mstHTRANS;
  assign bus.slvHMASTLOCK = pend ? hold.lock : bus.mstHMASTLOCK;
  assign bus.slvHWDATA    = bus.mstHWDATA;

  assign bus.mstHREADYOUT = ~pend & ~err1 & dp_ready;
  assign bus.mstHRESP     = err_any ? HRESP_ERROR : dp_resp;
  assign bus.mstHRDATA    = dp_rdata;
  assign bus.slvHREADY    = bus.mstHREADYOUT;

  assign cur_lock     = pend ? hold.lock : bus.mstHMASTLOCK;
  assign cur_seq_busy = pend ? hold.trans[0] : bus.mstHTRANS[0];
  assign bus.can_switch = ~((cur_lock ? asel : '0) | (dlock ? dsel : '0) |
                            (cur_seq_busy ? asel : '0) | (pend ? hold_sel : '0));

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state    <= ST_IDLE;
      hold     <= '0;
      hold_sel <= '0;
      dsel     <= '0;
      dlock    <= 1'b0;
    end else
      case (state)
        ST_IDLE:
          if (sample) begin
            if (!valid || dec_unmapped) begin
              dsel  <= '0;
              dlock <= 1'b0;
`ifdef RISCV_MASTER_PORT_DEFAULT_SLAVE_EN
              if (valid) state <= ST_ERR1;
`endif
            end else if (|(dec_hit & bus.slvGRANT & bus.slvHREADYOUT)) begin
              dsel  <= dec_hit;
              dlock <= bus.mstHMASTLOCK;
            end else begin
              state    <= ST_PEND;
              hold     <= '{addr: AHB_PLEN'(bus.mstHADDR), write: bus.mstHWRITE,
                            size: bus.mstHSIZE, burst: bus.mstHBURST, prot: bus.mstHPROT,
                            trans: bus.mstHTRANS, lock: bus.mstHMASTLOCK};
              hold_sel <= dec_hit;
              dsel     <= '0;
              dlock    <= 1'b0;
            end
          end
        ST_PEND:
          if (|(hold_sel & bus.slvGRANT & bus.slvHREADYOUT)) begin
            state <= ST_IDLE;
            dsel  <= hold_sel;
            dlock <= hold.lock;
          end
`ifdef RISCV_MASTER_PORT_DEFAULT_SLAVE_EN
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= ST_IDLE;
`endif
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_riscv_master_port.sv
// tb_riscv_master_port: directed and randomized transfers checked against a transaction-level model
module tb_riscv_master_port;
  import riscv_mpsoc_pkg::*;
  localparam int PLEN = 64, XLEN = 64, SLAVES = 8;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] base [SLAVES];
  logic [63:0] mask [SLAVES];

  riscv_master_port_if #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) bus ();
  riscv_master_port #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) dut (
    .HRESETn (HRESETn),
    .HCLK    (HCLK),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;
  assign bus.mstHREADY = bus.mstHREADYOUT;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_target(input logic [63:0] a);
    for (int s = 0; s < SLAVES; s++)
      if (((a ^ base[s]) & mask[s]) == 64'h0) return s;
    return -1;
  endfunction

  task automatic master_idle();
    bus.mstHSEL = 1'b0;
    bus.mstHTRANS = HTRANS_IDLE;
    bus.mstHMASTLOCK = 1'b0;
  endtask

  task automatic xfer(input logic [63:0] a, input logic wr, input logic [1:0] tr,
                      input logic lk, input int g);
    int t;
    logic [7:0] oh, nz, cs;
    logic [63:0] rd, wd;
    logic [2:0] sz;
    t = ref_target(a);
    oh = 8'(1) << t;
    rd = {$urandom, $urandom};
    wd = {$urandom, $urandom};
    sz = 3'($urandom);
    @(negedge HCLK);
    nz = 8'($urandom);
    bus.mstHSEL = 1'b1;
    bus.mstHADDR = a;
    bus.mstHWRITE = wr;
    bus.mstHTRANS = tr;
    bus.mstHMASTLOCK = lk;
    bus.mstHSIZE = sz;
    bus.mstHBURST = 3'($urandom);
    bus.mstHPROT = 4'($urandom);
    bus.slvHREADYOUT = nz | oh;
    bus.slvHRESP = nz & ~oh;
    bus.slvGRANT = (g == 0) ? (nz | oh) : (nz & ~oh);
    for (int s = 0; s < SLAVES; s++) bus.slvHRDATA[s] = {$urandom, $urandom};
    bus.slvHRDATA[t] = rd;
    #1;
    chk("addr_hsel", bus.slvHSEL, oh);
    chk("addr_ready", bus.mstHREADYOUT, 1'b1);
    chk("addr_trans", bus.slvHTRANS, tr);
    cs = (tr == HTRANS_SEQ || lk) ? ~oh : 8'hFF;
    chk("addr_canswitch", bus.can_switch, cs);
    for (int k = 1; k <= g; k++) begin
      @(negedge HCLK);
      nz = 8'($urandom);
      master_idle();
      bus.mstHADDR = {$urandom, $urandom};
      bus.mstHWRITE = ~wr;
      bus.mstHSIZE = 3'($urandom);
      bus.mstHWDATA = wd;
      bus.slvHREADYOUT = nz | oh;
      bus.slvHRESP = nz & ~oh;
      bus.slvGRANT = (k == g) ? (nz | oh) : (nz & ~oh);
      #1;
      cs = ~oh;
      chk("pend_hsel", bus.slvHSEL, oh);
      chk("pend_ready", bus.mstHREADYOUT, 1'b0);
      chk("pend_trans", bus.slvHTRANS, HTRANS_NONSEQ);
      chk("pend_addr", bus.slvHADDR, a);
      chk("pend_write", bus.slvHWRITE, wr);
      chk("pend_size", bus.slvHSIZE, sz);
      chk("pend_canswitch", bus.can_switch, cs);
    end
    @(negedge HCLK);
    nz = 8'($urandom);
    master_idle();
    bus.mstHWDATA = wd;
    bus.slvHREADYOUT = nz | oh;
    bus.slvHRESP = nz & ~oh;
    bus.slvGRANT = nz;
    #1;
    cs = lk ? ~oh : 8'hFF;
    chk("data_ready", bus.mstHREADYOUT, 1'b1);
    chk("data_resp", bus.mstHRESP, HRESP_OKAY);
    chk("data_rdata", bus.mstHRDATA, rd);
    chk("data_wdata", bus.slvHWDATA, wd);
    chk("data_canswitch", bus.can_switch, cs);
    @(negedge HCLK);
    #1;
    cs = 8'hFF;
    chk("after_rdata", bus.mstHRDATA, 64'h0);
    chk("after_ready", bus.mstHREADYOUT, 1'b1);
    chk("after_canswitch", bus.can_switch, cs);
  endtask

  initial begin
    logic [63:0] r4, r5, w1, w2, a;
    logic [3:0] rg;
    for (int s = 0; s < SLAVES; s++) begin
      base[s] = 64'(s) << 28;
      mask[s] = 64'hFFFF_FFFF_F000_0000;
    end
    // region 7 overlaps region 6 so the lowest-index rule is exercised
    base[7] = 64'h6000_0000;
    mask[7] = 64'hFFFF_FFFF_E000_0000;
    for (int s = 0; s < SLAVES; s++) begin
      bus.slvHADDR_BASE[s] = base[s];
      bus.slvHADDR_MASK[s] = mask[s];
      bus.slvHRDATA[s] = {$urandom, $urandom};
    end
    master_idle();
    bus.mstHADDR = 64'h0;
    bus.mstHWDATA = 64'h0;
    bus.mstHWRITE = 1'b0;
    bus.mstHSIZE = 3'd3;
    bus.mstHBURST = 3'd0;
    bus.mstHPROT = 4'd3;
    bus.slvHREADYOUT = 8'hFF;
    bus.slvHRESP = 8'hFF;
    bus.slvGRANT = 8'h00;
    #1;
    chk("rst_hsel", bus.slvHSEL, 8'h00);
    chk("rst_trans", bus.slvHTRANS, HTRANS_IDLE);
    chk("rst_canswitch", bus.can_switch, 8'hFF);
    chk("rst_ready", bus.mstHREADYOUT, 1'b1);
    chk("rst_resp", bus.mstHRESP, HRESP_OKAY);
    chk("rst_rdata", bus.mstHRDATA, 64'h0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    xfer(64'h2000_0000, 1'b0, HTRANS_NONSEQ, 1'b0, 0);
    xfer(64'h1000_0040, 1'b0, HTRANS_NONSEQ, 1'b0, 3);
    xfer(64'h3000_0008, 1'b1, HTRANS_SEQ, 1'b0, 2);
    xfer(64'h6000_0010, 1'b0, HTRANS_NONSEQ, 1'b0, 0);
    xfer(64'h7FFF_FFF8, 1'b1, HTRANS_NONSEQ, 1'b1, 1);

    // locked two-beat write to slave 0
    @(negedge HCLK);
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    bus.slvGRANT = 8'hFF;
    bus.slvHREADYOUT = 8'hFF;
    bus.mstHSEL = 1'b1;
    bus.mstHADDR = 64'h100;
    bus.mstHTRANS = HTRANS_NONSEQ;
    bus.mstHWRITE = 1'b1;
    bus.mstHMASTLOCK = 1'b1;
    #1;
    chk("lock_beat1_canswitch", bus.can_switch, 8'hFE);
    @(negedge HCLK);
    bus.mstHADDR = 64'h108;
    bus.mstHTRANS = HTRANS_SEQ;
    bus.mstHWDATA = w1;
    #1;
    chk("lock_beat2_canswitch", bus.can_switch, 8'hFE);
    chk("lock_beat2_trans", bus.slvHTRANS, HTRANS_SEQ);
    chk("lock_beat1_wdata", bus.slvHWDATA, w1);
    @(negedge HCLK);
    master_idle();
    bus.mstHWDATA = w2;
    #1;
    chk("lock_final_canswitch", bus.can_switch, 8'hFE);
    chk("lock_final_wdata", bus.slvHWDATA, w2);
    @(negedge HCLK);
    #1;
    chk("lock_release_canswitch", bus.can_switch, 8'hFF);

    // unmapped access
    @(negedge HCLK);
    bus.slvHRESP = 8'hFF;
    bus.mstHSEL = 1'b1;
    bus.mstHADDR = 64'hFFFF_0000;
    bus.mstHTRANS = HTRANS_NONSEQ;
    bus.mstHWRITE = 1'b0;
    #1;
    chk("unmapped_target", 64'(ref_target(64'hFFFF_0000) == -1), 64'h1);
    chk("unmapped_hsel", bus.slvHSEL, 8'h00);
    @(negedge HCLK);
    master_idle();
    #1;
`ifdef RISCV_MASTER_PORT_DEFAULT_SLAVE_EN
    chk("unmapped_err1_resp", bus.mstHRESP, HRESP_ERROR);
    chk("unmapped_err1_ready", bus.mstHREADYOUT, 1'b0);
    chk("unmapped_err1_hsel", bus.slvHSEL, 8'h00);
    @(negedge HCLK);
    #1;
    chk("unmapped_err2_resp", bus.mstHRESP, HRESP_ERROR);
    chk("unmapped_err2_ready", bus.mstHREADYOUT, 1'b1);
    @(negedge HCLK);
    #1;
    chk("unmapped_done_resp", bus.mstHRESP, HRESP_OKAY);
`else
    chk("unmapped_resp", bus.mstHRESP, HRESP_OKAY);
    chk("unmapped_ready", bus.mstHREADYOUT, 1'b1);
    chk("unmapped_rdata", bus.mstHRDATA, 64'h0);
`endif
    bus.slvHRESP = 8'h00;

    // slave wait state stalls the master and blocks the next address phase
    @(negedge HCLK);
    r4 = {$urandom, $urandom};
    r5 = {$urandom, $urandom};
    bus.slvHRDATA[4] = r4;
    bus.slvGRANT = 8'hFF;
    bus.slvHREADYOUT = 8'hFF;
    bus.mstHSEL = 1'b1;
    bus.mstHADDR = 64'h4000_0000;
    bus.mstHTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    bus.mstHADDR = 64'h5000_0010;
    bus.slvHREADYOUT = 8'hEF;
    #1;
    chk("wait_ready", bus.mstHREADYOUT, 1'b0);
    @(negedge HCLK);
    bus.slvHREADYOUT = 8'hFF;
    bus.slvHRDATA[5] = r5;
    #1;
    chk("wait_release_ready", bus.mstHREADYOUT, 1'b1);
    chk("wait_release_rdata", bus.mstHRDATA, r4);
    @(negedge HCLK);
    master_idle();
    #1;
    chk("wait_next_rdata", bus.mstHRDATA, r5);

    // reset while a request is pending
    @(negedge HCLK);
    bus.slvGRANT = 8'h00;
    bus.mstHSEL = 1'b1;
    bus.mstHADDR = 64'h1000_0000;
    bus.mstHTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    master_idle();
    #1;
    chk("rstpend_pending", bus.mstHREADYOUT, 1'b0);
    HRESETn = 1'b0;
    #1;
    chk("rstpend_hsel", bus.slvHSEL, 8'h00);
    chk("rstpend_ready", bus.mstHREADYOUT, 1'b1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus.slvGRANT = 8'hFF;
    #1;
    chk("rstpend_after_hsel", bus.slvHSEL, 8'h00);
    chk("rstpend_after_ready", bus.mstHREADYOUT, 1'b1);
    chk("rstpend_after_canswitch", bus.can_switch, 8'hFF);
    @(negedge HCLK);
    #1;
    chk("rstpend_no_completion", bus.mstHRDATA, 64'h0);

    // randomized transfers
    for (int i = 0; i < 40; i++) begin
      rg = 4'($urandom_range(0, 7));
      a = {32'h0, rg, 28'($urandom) & 28'hFFF_FFF8};
      xfer(a, 1'($urandom), $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ,
           1'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
